matmul_ctrl: RTL and testbench
==============================

Name: matmul_ctrl

Overview:
- Sequencer for the WIDTH x ROW x COL systolic matmul datapath.
- Latches one data_config_struct job on start and drives the weight-, input- and psum-memory read ports, the array's weight-push and valid strobes, and the output-memory write port.
- Sits between the host/config register block and the array + local SRAMs; one job at a time.

Parameters:
- ROW, 4, array rows; weight-push cycles max = ROW
- COL, 4, array columns
- W_SIZE, 256, weight memory depth
- I_SIZE, 256, input memory depth
- O_SIZE, 256, psum/output memory depth

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  sync abort; return to IDLE next cycle
- cfg  in  data_config_struct  job descriptor
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on job completion
- w_rd_en  out  1  weight memory read enable
- w_rd_addr  out  $clog2(W_SIZE)  weight read address
- i_rd_en  out  1  input memory read enable
- i_rd_addr  out  $clog2(I_SIZE)  input read address
- p_rd_en  out  1  psum memory read enable
- p_rd_addr  out  $clog2(O_SIZE)  psum read address
- arr_weight_en  out  1  array weight push (memory data valid this cycle)
- arr_valid  out  1  array input/psum valid
- arr_accum_en  out  1  psum input selected (latched accum_en)
- arr_out_valid  in  1  array result row valid
- o_wr_en  out  1  output memory write enable
- o_wr_addr  out  $clog2(O_SIZE)  output write address

Behaviour:
- Reset: state IDLE; all outputs 0; counters and latched cfg cleared.
- Counts: NW = cfg.w_rows+1 (1..ROW); NI = cfg.i_rows+1 (1..I_SIZE).
- Memory read latency is fixed at 1 cycle. arr_weight_en and arr_valid are the corresponding read enables delayed one cycle through registers.
- IDLE: when start=1, latch cfg and clear counters; next state LOAD_W. start is ignored while busy.
- LOAD_W: NW cycles. w_rd_en=1; w_rd_addr = w_offset + k for k = 0..NW-1. Then STREAM.
- STREAM: NI cycles. i_rd_en=1; i_rd_addr = i_offset + k. p_rd_en = accum_en; p_rd_addr = psum_offset + k. Then WAIT_OUT.
- Output capture: active in STREAM and WAIT_OUT. Each arr_out_valid drives o_wr_en=1 in the same cycle, o_wr_addr = o_offset_w + m. m increments after each write.
- WAIT_OUT: when the NI-th write occurs, go to DONE. If that write coincides with the last STREAM cycle, go straight from STREAM to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. The delayed strobes are drained and guaranteed 0 at this point.
- Address arithmetic: modulo memory depth; addresses wrap silently, e.g. offset 254 + 3 -> 1.
- arr_out_valid in IDLE, LOAD_W or DONE: ignored, no write.
- Extra arr_out_valid beyond NI: ignored.
- abort: takes priority over all transitions. Next cycle is IDLE with all enables and delayed strobes cleared. No done pulse.
- start and abort both high in IDLE: remain IDLE.
- rst_n low mid-job: immediate IDLE, outputs 0. Partially written outputs are not rolled back.
- arr_accum_en holds the latched cfg.accum_en while busy; 0 in IDLE.

Decomposition:
- matrix_mult_pkg holds:
  - data_config_struct
  - ROW, COL, W_SIZE, I_SIZE, O_SIZE
  - new ctrl_state_e enum: IDLE, LOAD_W, STREAM, WAIT_OUT, DONE
- Sub-module ctrl_addr_gen: base + counter with modulo-depth wrap, load/increment/clear. Instantiated four times: weight, input, psum, output.

Test Plan:
- Basic job: cfg w_rows=3, i_rows=7, offsets 0x10/0x20/0x30/0x40, accum_en=0; array model returns out_valid 7 cycles after each valid.
  - w_rd_addr 0x10..0x13, then i_rd_addr 0x20..0x27.
  - p_rd_en never asserted.
  - Eight writes to 0x40..0x47.
  - done exactly once; busy low afterwards.
- Accumulate: accum_en=1, psum_offset=0x80.
  - p_rd_addr 0x80..0x87 aligned cycle-for-cycle with i_rd_addr.
  - arr_accum_en=1 throughout the job.
- Wrap: i_offset=0xFE, i_rows=3 -> i_rd_addr sequence FE, FF, 00, 01. o_offset_w=0xFF -> writes to FF, 00, 01, 02.
- Latency alignment:
  - arr_weight_en equals w_rd_en delayed by exactly 1 cycle.
  - arr_valid equals i_rd_en delayed by exactly 1 cycle.
  - Check across 4 weight pushes (w_rows=3).
- Abort/reset:
  - abort on the 3rd STREAM cycle -> IDLE next cycle, all enables 0, no done.
  - Repeat with rst_n low -> asynchronous clear of all outputs.
  - New start afterwards completes correctly.
- Spurious/overlap:
  - start pulses while busy are ignored.
  - arr_out_valid in IDLE produces no write.
  - Ninth out_valid after 8 writes produces no write.
  - out_valid on the last STREAM cycle with i_rows=0 -> DONE next cycle.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared types and sizing for the systolic matmul controller and its helpers.
package matrix_mult_pkg;

  localparam int ROW    = 4;
  localparam int COL    = 4;
  localparam int W_SIZE = 256;
  localparam int I_SIZE = 256;
  localparam int O_SIZE = 256;

  localparam int WAW = $clog2(W_SIZE);
  localparam int IAW = $clog2(I_SIZE);
  localparam int OAW = $clog2(O_SIZE);
  localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;

  // Row counts are stored minus one so the full range fits the field.
  typedef struct packed {
    logic [RW-1:0]  w_rows;
    logic [IAW-1:0] i_rows;
    logic [WAW-1:0] w_offset;
    logic [IAW-1:0] i_offset;
    logic [OAW-1:0] psum_offset;
    logic [OAW-1:0] o_offset_w;
    logic           accum_en;
  } data_config_struct;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    WAIT_OUT,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/ctrl_addr_gen.sv
// Base-plus-count address generator; the running address wraps at DEPTH.
module ctrl_addr_gen #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] addr_reg;
  logic [AW-1:0] addr_next;

  always_comb begin
    addr_next = addr_reg;
    if (clear) begin
      addr_next = '0;
    end else if (load) begin
      addr_next = base;
    end else if (inc) begin
      addr_next = (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= addr_next;
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/matmul_ctrl.sv
// Job sequencer for the systolic matmul array: weight load, input/psum stream,
// then output capture until every result row has been written.
module matmul_ctrl
  import matrix_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  data_config_struct cfg,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [WAW-1:0]    w_rd_addr,
  output logic              i_rd_en,
  output logic [IAW-1:0]    i_rd_addr,
  output logic              p_rd_en,
  output logic [OAW-1:0]    p_rd_addr,
  output logic              arr_weight_en,
  output logic              arr_valid,
  output logic              arr_accum_en,
  input  logic              arr_out_valid,
  output logic              o_wr_en,
  output logic [OAW-1:0]    o_wr_addr
);

  ctrl_state_e       state_reg, state_next;
  data_config_struct cfg_reg;
  logic [IAW-1:0]    cnt_reg;
  logic [IAW:0]      m_reg, m_next;
  logic [IAW:0]      ni;
  logic              arr_weight_en_reg, arr_valid_reg;
  logic              accept, capture, load_last, stream_last, keep_strobes;

  assign accept      = (state_reg == IDLE) && start && !abort;
  assign capture     = (state_reg == STREAM) || (state_reg == WAIT_OUT);
  assign ni          = {1'b0, cfg_reg.i_rows} + (IAW+1)'(1);
  assign load_last   = (cnt_reg == IAW'(cfg_reg.w_rows));
  assign stream_last = (cnt_reg == cfg_reg.i_rows);

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign w_rd_en      = (state_reg == LOAD_W);
  assign i_rd_en      = (state_reg == STREAM);
  assign p_rd_en      = (state_reg == STREAM) && cfg_reg.accum_en;
  assign arr_accum_en = busy && cfg_reg.accum_en;
  // Writes beyond the expected row count are dropped.
  assign o_wr_en      = capture && arr_out_valid && (m_reg != ni);
  assign m_next       = m_reg + (IAW+1)'(o_wr_en);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = LOAD_W;
      LOAD_W:   if (load_last) state_next = STREAM;
      STREAM:   if (stream_last) state_next = (m_next == ni) ? DONE : WAIT_OUT;
      WAIT_OUT: if (m_next == ni) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Delayed strobes are dropped on the way into DONE/IDLE so both end quiet.
  assign keep_strobes = (state_next == LOAD_W) || (state_next == STREAM) ||
                        (state_next == WAIT_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      cfg_reg           <= '0;
      cnt_reg           <= '0;
      m_reg             <= '0;
      arr_weight_en_reg <= 1'b0;
      arr_valid_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      arr_weight_en_reg <= w_rd_en && keep_strobes;
      arr_valid_reg     <= i_rd_en && keep_strobes;
      if (accept) cfg_reg <= cfg;
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (w_rd_en || i_rd_en) begin
        cnt_reg <= cnt_reg + IAW'(1);
      end
      m_reg <= accept ? '0 : m_next;
    end
  end

  assign arr_weight_en = arr_weight_en_reg;
  assign arr_valid     = arr_valid_reg;

  ctrl_addr_gen #(.DEPTH(W_SIZE), .AW(WAW)) u_w_addr (
    .clk(clk), .rst_n(rst_n), .clear(abort), .load(accept), .inc(w_rd_en),
    .base(cfg.w_offset), .addr(w_rd_addr)
  );

  ctrl_addr_gen #(.DEPTH(I_SIZE), .AW(IAW)) u_i_addr (
    .clk(clk), .rst_n(rst_n), .clear(abort), .load(accept), .inc(i_rd_en),
    .base(cfg.i_offset), .addr(i_rd_addr)
  );

  ctrl_addr_gen #(.DEPTH(O_SIZE), .AW(OAW)) u_p_addr (
    .clk(clk), .rst_n(rst_n), .clear(abort), .load(accept), .inc(p_rd_en),
    .base(cfg.psum_offset), .addr(p_rd_addr)
  );

  ctrl_addr_gen #(.DEPTH(O_SIZE), .AW(OAW)) u_o_addr (
    .clk(clk), .rst_n(rst_n), .clear(abort), .load(accept), .inc(o_wr_en),
    .base(cfg.o_offset_w), .addr(o_wr_addr)
  );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with a 7-cycle array latency model.
module tb_matmul_ctrl;
  import matrix_mult_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  data_config_struct cfg;
  logic busy, done, w_rd_en, i_rd_en, p_rd_en, o_wr_en;
  logic arr_weight_en, arr_valid, arr_accum_en, arr_out_valid;
  logic [WAW-1:0] w_rd_addr;
  logic [IAW-1:0] i_rd_addr;
  logic [OAW-1:0] p_rd_addr, o_wr_addr;

  matmul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg(cfg),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr),
    .arr_weight_en(arr_weight_en), .arr_valid(arr_valid),
    .arr_accum_en(arr_accum_en), .arr_out_valid(arr_out_valid),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr)
  );

  always #5 clk = ~clk;

  // Array model: result row appears 7 cycles after each arr_valid.
  logic [6:0] pipe = '0;
  logic model_en = 1'b1;
  logic force_ov = 1'b0;
  always @(posedge clk) pipe <= {pipe[5:0], arr_valid};
  assign arr_out_valid = (model_en & pipe[6]) | force_ov;

  int total = 0;
  int bad = 0;
  int w_q[$], i_q[$], p_q[$], o_q[$];
  int done_cnt, lat_w_err, lat_i_err, acc_err, align_err, wpush;
  logic prev_w = 1'b0, prev_i = 1'b0;
  logic lat_chk_en = 1'b0;
  logic exp_accum = 1'b0;

  always @(negedge clk) begin
    if (w_rd_en) w_q.push_back(int'(w_rd_addr));
    if (i_rd_en) i_q.push_back(int'(i_rd_addr));
    if (p_rd_en) p_q.push_back(int'(p_rd_addr));
    if (o_wr_en) o_q.push_back(int'(o_wr_addr));
    if (done) done_cnt++;
    if (arr_weight_en) wpush++;
    if (lat_chk_en) begin
      if (arr_weight_en !== prev_w) lat_w_err++;
      if (arr_valid !== prev_i) lat_i_err++;
    end
    if (p_rd_en !== (i_rd_en & exp_accum)) align_err++;
    if (arr_accum_en !== (busy & exp_accum)) acc_err++;
    prev_w = w_rd_en;
    prev_i = i_rd_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int q[$], input int base, input int n,
                           input int depth);
    check({tag, "_len"}, q.size(), n);
    for (int k = 0; k < n && k < q.size(); k++)
      check($sformatf("%s[%0d]", tag, k), q[k], (base + k) % depth);
  endtask

  function automatic data_config_struct mk_cfg(input int wr, input int ir, input int wo,
                                               input int io, input int po, input int oo,
                                               input logic acc);
    data_config_struct c;
    c.w_rows      = RW'(wr);
    c.i_rows      = IAW'(ir);
    c.w_offset    = WAW'(wo);
    c.i_offset    = IAW'(io);
    c.psum_offset = OAW'(po);
    c.o_offset_w  = OAW'(oo);
    c.accum_en    = acc;
    return c;
  endfunction

  task automatic clear_mon();
    w_q.delete(); i_q.delete(); p_q.delete(); o_q.delete();
    done_cnt = 0; lat_w_err = 0; lat_i_err = 0; acc_err = 0; align_err = 0; wpush = 0;
  endtask

  task automatic drive_start(input data_config_struct c);
    @(posedge clk); #1;
    cfg = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_job(input string tag, input data_config_struct c, input bit spur);
    bit ok;
    clear_mon();
    exp_accum = c.accum_en;
    drive_start(c);
    if (spur) begin
      cfg = mk_cfg(1, 1, 'hAA, 'hAA, 'hAA, 'hAA, 1'b0);
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(400, ok);
    check({tag, "_done_seen"}, 32'(ok), 1);
    repeat (12) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_accum_flag"}, acc_err, 0);
    check({tag, "_psum_align"}, align_err, 0);
    $display("job %s: wr=%0d in=%0d ps=%0d out=%0d", tag, w_q.size(), i_q.size(),
             p_q.size(), o_q.size());
  endtask

  task automatic wait_third_stream(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (i_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    cfg = '0;
    #3;
    check("rst_strobes", {busy, done, w_rd_en, i_rd_en, p_rd_en, arr_weight_en, arr_valid,
                          arr_accum_en, o_wr_en}, 0);
    check("rst_addrs", {w_rd_addr, i_rd_addr, p_rd_addr, o_wr_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic job with latency alignment checking
    lat_chk_en = 1'b1;
    run_job("basic", mk_cfg(3, 7, 'h10, 'h20, 'h30, 'h40, 1'b0), 1'b0);
    lat_chk_en = 1'b0;
    check_seq("basic_w", w_q, 'h10, 4, W_SIZE);
    check_seq("basic_i", i_q, 'h20, 8, I_SIZE);
    check("basic_no_psum", p_q.size(), 0);
    check_seq("basic_o", o_q, 'h40, 8, O_SIZE);
    check("lat_weight", lat_w_err, 0);
    check("lat_valid", lat_i_err, 0);
    check("weight_pushes", wpush, 4);

    // Accumulate
    run_job("accum", mk_cfg(1, 7, 'h00, 'h20, 'h80, 'h60, 1'b1), 1'b0);
    check_seq("accum_i", i_q, 'h20, 8, I_SIZE);
    check_seq("accum_p", p_q, 'h80, 8, O_SIZE);
    check_seq("accum_o", o_q, 'h60, 8, O_SIZE);

    // Address wrap
    run_job("wrap", mk_cfg(0, 3, 'hFF, 'hFE, 'h00, 'hFF, 1'b0), 1'b0);
    check_seq("wrap_w", w_q, 'hFF, 1, W_SIZE);
    check_seq("wrap_i", i_q, 'hFE, 4, I_SIZE);
    check_seq("wrap_o", o_q, 'hFF, 4, O_SIZE);

    // Abort on third STREAM cycle
    clear_mon();
    exp_accum = 1'b0;
    drive_start(mk_cfg(1, 7, 'h00, 'h20, 'h00, 'h40, 1'b0));
    wait_third_stream(ok);
    check("abort_stream_seen", 32'(ok), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, done, w_rd_en, i_rd_en, p_rd_en, o_wr_en, arr_weight_en,
                         arr_valid}, 0);
    force_ov = 1'b1;
    @(negedge clk);
    check("idle_ov_no_write", 32'(o_wr_en), 0);
    @(posedge clk); #1;
    force_ov = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_writes", o_q.size(), 0);
    check("abort_reads", i_q.size(), 3);
    $display("job abort: in=%0d out=%0d", i_q.size(), o_q.size());

    // Asynchronous reset mid-job
    clear_mon();
    exp_accum = 1'b1;
    drive_start(mk_cfg(1, 7, 'h00, 'h20, 'h80, 'h40, 1'b1));
    wait_third_stream(ok);
    check("reset_stream_seen", 32'(ok), 1);
    rst_n = 1'b0;
    #1;
    check("reset_clear", {busy, done, w_rd_en, i_rd_en, p_rd_en, o_wr_en, arr_weight_en,
                          arr_valid, arr_accum_en}, 0);
    check("reset_addr", {i_rd_addr, p_rd_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("reset_no_done", done_cnt, 0);
    $display("job reset: in=%0d", i_q.size());

    // Restart with start pulses and junk cfg while busy
    run_job("restart", mk_cfg(3, 7, 'h30, 'h50, 'h00, 'h70, 1'b0), 1'b1);
    check_seq("restart_w", w_q, 'h30, 4, W_SIZE);
    check_seq("restart_i", i_q, 'h50, 8, I_SIZE);
    check_seq("restart_o", o_q, 'h70, 8, O_SIZE);

    // Single row: write on the only STREAM cycle goes straight to DONE
    model_en = 1'b0;
    clear_mon();
    exp_accum = 1'b0;
    drive_start(mk_cfg(0, 0, 'h00, 'h00, 'h00, 'h90, 1'b0));
    @(posedge clk); #1;
    force_ov = 1'b1;
    @(negedge clk);
    check("single_stream", 32'(i_rd_en), 1);
    check("single_write", 32'(o_wr_en), 1);
    check("single_addr", 32'(o_wr_addr), 'h90);
    @(negedge clk);
    check("single_done", 32'(done), 1);
    check("single_done_nowrite", 32'(o_wr_en), 0);
    check("single_drained", {arr_valid, arr_weight_en}, 0);
    @(posedge clk); #1;
    force_ov = 1'b0;
    @(negedge clk);
    check("single_idle", 32'(busy), 0);
    $display("job single: out=%0d", o_q.size());

    // Ninth valid after eight writes is ignored
    clear_mon();
    drive_start(mk_cfg(0, 7, 'h00, 'h00, 'h00, 'h50, 1'b0));
    @(posedge clk); #1;
    force_ov = 1'b1;
    wait_done(40, ok);
    check("ninth_done_seen", 32'(ok), 1);
    check("ninth_no_write", 32'(o_wr_en), 0);
    repeat (3) @(negedge clk);
    force_ov = 1'b0;
    check_seq("ninth_o", o_q, 'h50, 8, O_SIZE);
    check("ninth_done_once", done_cnt, 1);
    $display("job ninth: out=%0d", o_q.size());
    model_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
